mdu_multicycle: RTL
===================

Name: mdu_multicycle

Overview:
- Parameterised multi-cycle multiply/divide unit with HI/LO result registers.
- Sits beside the combinational ALU in the EX stage and executes mult/multu/div/divu/mthi/mtlo.
- Extends the ALU concept with signed/unsigned widening multiply, divide with remainder, configurable latency, a busy handshake and architectural state.
- Pipeline control stalls any MDU-dependent instruction while busy is high.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for mult/multu; must be at least 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; md_op, A and B are sampled with it.
- md_op  input  3  operation code (encodings in package).
- A  input  WIDTH  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  WIDTH  operand rt (divisor / multiplier).
- busy  output  1  registered; high while an operation is in flight.
- hi  output  WIDTH  HI register value.
- lo  output  WIDTH  LO register value.

Behaviour:
- Reset (synchronous, active-high):
  - busy=0, hi=0, lo=0, cycle counter=0, pending result discarded.
  - Reset overrides start in the same cycle.
  - Reset mid-operation aborts the operation; no HI/LO write follows.
- Accept rule: start is honoured only at an edge where busy=0 and reset=0. While busy=1, start is ignored entirely: no queueing and no HI/LO change.
- mthi/mtlo:
  - Single-edge write: hi<=A (mthi) or lo<=A (mtlo) at the accepting edge.
  - busy stays 0.
- mult/multu/div/divu, accepted at edge E0:
  - Operands are captured, or the result is computed into shadow registers.
  - Counter loaded with N (MULT_CYCLES or DIV_CYCLES); busy=1 after E0.
  - Counter decrements each edge.
  - At edge E_N: hi/lo update and busy=0. busy is therefore high for exactly N cycles.
  - The new hi/lo are visible in the cycle busy first reads 0.
  - A new start is accepted in that same cycle.
- hi/lo hold their old values for the whole busy window; operand changes after E0 have no effect.
- mult: signed WIDTH x WIDTH product, 2*WIDTH bits; hi=upper half, lo=lower half.
- multu: same as mult, with operands zero-extended.
- div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu): lo=all ones, hi=A; busy duration unchanged.
- Signed overflow (A=most negative value, B=-1): lo=A, hi=0.
- Reserved md_op codes with start=1 are a no-op; busy stays 0.
- The result computation may be one combinational stage into shadow registers at accept, or an iterative engine. Either way it must meet the exact latency above.

Decomposition:
- Package mdu_pkg holds the md_op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; 6 and 7 reserved.
- mdu_pkg also holds a helper constant for the counter width, clog2 of max(MULT_CYCLES, DIV_CYCLES)+1.
- One natural sub-module: mdu_core. It is combinational and maps (md_op, A, B) to {hi_res, lo_res}, including the divide-by-zero and overflow rules.
- The top level owns the counter, busy, shadow and HI/LO registers.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu with A=7, B=0 → after 10 cycles lo=0xFFFFFFFF, hi=7.
- div with A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start div, then:
  - assert start (mtlo, A=0x1234) on cycle 3 of busy → ignored; final lo is the quotient.
  - repeat with reset on cycle 4 → hi=lo=0, busy=0 next cycle, no later write.
  - mthi A=0xABCD with busy=0 → hi=0xABCD after one edge, busy never rises.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation encodings and the counter-width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Counter must hold the larger of the two latencies.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational result datapath: maps (md_op, a, b) to the HI/LO pair,
// including the divide-by-zero and signed-overflow special cases.
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] prod;

    always_comb begin
        prod   = '0;
        hi_res = '0;
        lo_res = '0;
        case (md_op_e'(md_op))
            MD_MULT: begin
                // Sign-extend to full width so the low 2*WIDTH bits are the signed product.
                prod   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
                hi_res = prod[2*WIDTH-1:WIDTH];
                lo_res = prod[WIDTH-1:0];
            end
            MD_MULTU: begin
                prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                hi_res = prod[2*WIDTH-1:WIDTH];
                lo_res = prod[WIDTH-1:0];
            end
            MD_DIV: begin
                if (b == '0) begin
                    lo_res = '1;
                    hi_res = a;
                end else if (a == MOST_NEG && b == '1) begin
                    lo_res = a;
                    hi_res = '0;
                end else begin
                    lo_res = $signed(a) / $signed(b);
                    hi_res = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (b == '0) begin
                    lo_res = '1;
                    hi_res = a;
                end else begin
                    lo_res = a / b;
                    hi_res = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit: the result is computed at accept into
// shadow registers and committed to HI/LO after a fixed latency.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] hi_sh_reg, hi_sh_next;
    logic [WIDTH-1:0] lo_sh_reg, lo_sh_next;
    logic [WIDTH-1:0] core_hi, core_lo;

    mdu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .md_op  (md_op),
        .a      (A),
        .b      (B),
        .hi_res (core_hi),
        .lo_res (core_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            hi_sh_reg <= '0;
            lo_sh_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            hi_sh_reg <= hi_sh_next;
            lo_sh_reg <= lo_sh_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        hi_sh_next = hi_sh_reg;
        lo_sh_next = lo_sh_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT, MD_MULTU: begin
                            state_next = ST_BUSY;
                            cnt_next   = CW'(MULT_CYCLES);
                            hi_sh_next = core_hi;
                            lo_sh_next = core_lo;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_next = ST_BUSY;
                            cnt_next   = CW'(DIV_CYCLES);
                            hi_sh_next = core_hi;
                            lo_sh_next = core_lo;
                        end
                        MD_MTHI: hi_next = A;
                        MD_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg - CW'(1);
                // Last busy cycle: commit on this edge so busy drops with the new HI/LO.
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_IDLE;
                    hi_next    = hi_sh_reg;
                    lo_next    = lo_sh_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_BUSY);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
